// File: rtl/tick_gen_cfg_sched.sv
// Round-robin scheduler sharing one baud/clock tick generator between NUM_REQ requesters.
// Each grant is validated, then the generator is taken through disable -> load -> enable
// and the requester is acked once both ticks have been seen.
// Optional feature macro: CFG_SCHED_TIMEOUT_EN (bounded wait for ticks in WAIT_TICK).
module tick_gen_cfg_sched #(
    parameter int unsigned       NUM_REQ    = 2,
    parameter int unsigned       CNT_W      = 32,
    parameter logic [CNT_W-1:0]  SYS_CLK_HZ = 100_000,
    parameter int unsigned       DIS_CYCLES = 2,
    parameter int unsigned       TIMEOUT    = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CNT_W-1:0]   req_baud,
    input  logic [NUM_REQ*CNT_W-1:0]   req_rclk,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         err,
    output logic                       busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                       gen_en,
    output logic [CNT_W-1:0]           gen_system_clk,
    output logic [CNT_W-1:0]           gen_baud_rate,
    output logic [CNT_W-1:0]           gen_required_clk,
    input  logic                       baud_tick,
    input  logic                       clk_tick
);

    localparam int unsigned      IdW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned      DisW    = (DIS_CYCLES > 1) ? $clog2(DIS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HalfClk = SYS_CLK_HZ >> 1;

    typedef enum logic [2:0] {
        StIdle, StCheck, StReject, StDisable, StLoad, StEnable, StWaitTick, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [IdW-1:0]     grant_q, grant_d;
    logic [IdW-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]   lat_baud_q, lat_baud_d;
    logic [CNT_W-1:0]   lat_rclk_q, lat_rclk_d;
    logic [DisW-1:0]    dis_cnt_q, dis_cnt_d;
    logic               seen_baud_q, seen_baud_d;
    logic               seen_clk_q, seen_clk_d;
    logic               gen_en_q, gen_en_d;
    logic [CNT_W-1:0]   gen_sys_q, gen_sys_d;
    logic [CNT_W-1:0]   gen_baud_q, gen_baud_d;
    logic [CNT_W-1:0]   gen_rclk_q, gen_rclk_d;

    logic               pick_found;
    logic [IdW-1:0]     pick_id;
    logic [CNT_W-1:0]   pick_baud;
    logic [CNT_W-1:0]   pick_rclk;

`ifdef CFG_SCHED_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
`endif

    // First requesting index at or after the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        pick_baud  = '0;
        pick_rclk  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_q) + k) % NUM_REQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = IdW'(idx);
                pick_baud  = req_baud[idx*CNT_W +: CNT_W];
                pick_rclk  = req_rclk[idx*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state logic for the sequencing FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        lat_baud_d  = lat_baud_q;
        lat_rclk_d  = lat_rclk_q;
        dis_cnt_d   = dis_cnt_q;
        seen_baud_d = seen_baud_q;
        seen_clk_d  = seen_clk_q;
        gen_en_d    = gen_en_q;
        gen_sys_d   = gen_sys_q;
        gen_baud_d  = gen_baud_q;
        gen_rclk_d  = gen_rclk_q;
`ifdef CFG_SCHED_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d    = pick_id;
                    rr_d       = (32'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + 1'b1;
                    lat_baud_d = pick_baud;
                    lat_rclk_d = pick_rclk;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if ((lat_baud_q == '0) || (lat_rclk_q == '0) ||
                    (lat_baud_q > HalfClk) || (lat_rclk_q > HalfClk)) begin
                    state_d = StReject;
                end else begin
                    gen_en_d  = 1'b0;
                    dis_cnt_d = '0;
                    state_d   = StDisable;
                end
            end
            StReject: begin
                state_d = StIdle;
            end
            StDisable: begin
                if (dis_cnt_q == DisW'(DIS_CYCLES - 1)) begin
                    // New config becomes visible during the LOAD cycle, still disabled.
                    gen_sys_d  = SYS_CLK_HZ;
                    gen_baud_d = lat_baud_q;
                    gen_rclk_d = lat_rclk_q;
                    state_d    = StLoad;
                end else begin
                    dis_cnt_d = dis_cnt_q + 1'b1;
                end
            end
            StLoad: begin
                gen_en_d = 1'b1;
                state_d  = StEnable;
            end
            StEnable: begin
                seen_baud_d = 1'b0;
                seen_clk_d  = 1'b0;
`ifdef CFG_SCHED_TIMEOUT_EN
                tmo_cnt_d   = '0;
`endif
                state_d     = StWaitTick;
            end
            StWaitTick: begin
                seen_baud_d = seen_baud_q | baud_tick;
                seen_clk_d  = seen_clk_q | clk_tick;
                if ((seen_baud_q | baud_tick) && (seen_clk_q | clk_tick)) begin
                    state_d = StDone;
                end
`ifdef CFG_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
                    // Give up: park the generator disabled and report through REJECT.
                    gen_en_d = 1'b0;
                    state_d  = StReject;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= '0;
            lat_baud_q  <= '0;
            lat_rclk_q  <= '0;
            dis_cnt_q   <= '0;
            seen_baud_q <= 1'b0;
            seen_clk_q  <= 1'b0;
            gen_en_q    <= 1'b0;
            gen_sys_q   <= '0;
            gen_baud_q  <= '0;
            gen_rclk_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            lat_baud_q  <= lat_baud_d;
            lat_rclk_q  <= lat_rclk_d;
            dis_cnt_q   <= dis_cnt_d;
            seen_baud_q <= seen_baud_d;
            seen_clk_q  <= seen_clk_d;
            gen_en_q    <= gen_en_d;
            gen_sys_q   <= gen_sys_d;
            gen_baud_q  <= gen_baud_d;
            gen_rclk_q  <= gen_rclk_d;
        end
    end

`ifdef CFG_SCHED_TIMEOUT_EN
    // Tick-wait timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    // One-hot ack/err pulses decoded from the state and the current grant.
    always_comb begin
        ack = '0;
        err = '0;
        if (state_q == StDone) begin
            ack[grant_q] = 1'b1;
        end
        if (state_q == StReject) begin
            err[grant_q] = 1'b1;
        end
    end

    assign busy             = (state_q != StIdle);
    assign grant_id         = grant_q;
    assign gen_en           = gen_en_q;
    assign gen_system_clk   = gen_sys_q;
    assign gen_baud_rate    = gen_baud_q;
    assign gen_required_clk = gen_rclk_q;

endmodule

// File: tb/tb_tick_gen_cfg_sched.sv
// Self-checking bench for tick_gen_cfg_sched: directed and randomised requests checked
// against a transaction-level model of arbitration, validation and generator config.
module tb_tick_gen_cfg_sched;

    localparam int unsigned NREQ = 2;
    localparam int unsigned W    = 32;
    localparam int unsigned SYSC = 100_000;
    localparam int unsigned DIS  = 2;
    localparam int unsigned TMO  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   req_baud;
    logic [NREQ*W-1:0]   req_rclk;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     err;
    logic                busy;
    logic [0:0]          grant_id;
    logic                gen_en;
    logic [W-1:0]        gen_system_clk;
    logic [W-1:0]        gen_baud_rate;
    logic [W-1:0]        gen_required_clk;
    logic                baud_tick;
    logic                clk_tick;

    tick_gen_cfg_sched #(
        .NUM_REQ    (NREQ),
        .CNT_W      (W),
        .SYS_CLK_HZ (32'(SYSC)),
        .DIS_CYCLES (DIS),
        .TIMEOUT    (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_baud         (req_baud),
        .req_rclk         (req_rclk),
        .ack              (ack),
        .err              (err),
        .busy             (busy),
        .grant_id         (grant_id),
        .gen_en           (gen_en),
        .gen_system_clk   (gen_system_clk),
        .gen_baud_rate    (gen_baud_rate),
        .gen_required_clk (gen_required_clk),
        .baud_tick        (baud_tick),
        .clk_tick         (clk_tick)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: round-robin pointer and the config the generator should hold.
    int          rr_m;
    logic        en_m;
    logic [31:0] sys_m, baud_m, rclk_m;
    logic [31:0] rb [NREQ];
    logic [31:0] rc [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cfg_ok(input logic [31:0] b, input logic [31:0] r);
        return (b != 0) && (r != 0) && (b <= SYSC / 2) && (r <= SYSC / 2);
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'(SYSC / 2);
            3:       return 32'(SYSC / 2 + 1);
            4:       return 32'($urandom_range(1, SYSC / 2));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        rr_m   = 0;
        en_m   = 1'b0;
        sys_m  = '0;
        baud_m = '0;
        rclk_m = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request/response exchange. Ticks are pulsed db/dc cycles into the wait;
    // with use_ticks=0 no ticks are given (timeout build only).
    task automatic transact(input logic [1:0] mask, input logic [1:0] after,
                            input int db, input int dc, input bit use_ticks);
        int          g;
        bit          ok;
        bit          got;
        int          lows;
        int          last;
        int          err_at;
        logic [31:0] onehot;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr_m + k) % NREQ;
            if (g < 0 && mask[idx]) g = idx;
        end
        rr_m   = (g + 1) % NREQ;
        ok     = cfg_ok(rb[g], rc[g]);
        onehot = 32'(1) << g;
        req      = mask;
        req_baud = {rb[1], rb[0]};
        req_rclk = {rc[1], rc[0]};

        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            got = busy;
        end
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(g));
        chk("no_resp_at_grant", 32'({ack, err}), 32'd0);

        if (!ok) begin
            // Rejected: err right after the check cycle, generator left alone.
            step();
            chk("reject_err", 32'(err), onehot);
            chk("reject_ack", 32'(ack), 32'd0);
            chk("reject_gen_en", 32'(gen_en), 32'(en_m));
            chk("reject_baud", gen_baud_rate, baud_m);
            chk("reject_rclk", gen_required_clk, rclk_m);
            req = after;
            step();
            chk("err_pulse", 32'(err), 32'd0);
            return;
        end

        // Generator is held off for the disable window plus the load cycle.
        lows = 0;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (gen_en) got = 1'b1;
            else lows++;
        end
        chk("gen_en_low_cycles", 32'(lows), 32'(DIS + 1));
        chk("gen_baud", gen_baud_rate, rb[g]);
        chk("gen_rclk", gen_required_clk, rc[g]);
        chk("gen_sys", gen_system_clk, 32'(SYSC));
        en_m   = 1'b1;
        sys_m  = 32'(SYSC);
        baud_m = rb[g];
        rclk_m = rc[g];

        step();  // first cycle of the tick wait
        if (use_ticks) begin
            last = (db > dc) ? db : dc;
            for (int n = 0; n <= last; n++) begin
                baud_tick = (n == db);
                clk_tick  = (n == dc);
                step();
                baud_tick = 1'b0;
                clk_tick  = 1'b0;
                chk("ack_timing", 32'(ack), (n == last) ? onehot : 32'd0);
            end
            chk("ack_no_err", 32'(err), 32'd0);
            req = after;
            step();
            chk("ack_pulse", 32'(ack), 32'd0);
        end else begin
            err_at = 0;
            for (int k = 1; k <= TMO + 4 && err_at == 0; k++) begin
                if (err != 0) err_at = k;
                else step();
            end
            // Counted from the first wait cycle: TMO wait cycles, then err.
            chk("timeout_cycle", 32'(err_at), 32'(TMO + 1));
            chk("timeout_err", 32'(err), onehot);
            chk("timeout_gen_en", 32'(gen_en), 32'd0);
            en_m = 1'b0;
            req  = after;
            step();
            chk("timeout_err_pulse", 32'(err), 32'd0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req       = 2'b11;
        req_baud  = {32'd9600, 32'd9600};
        req_rclk  = {32'd1000, 32'd1000};
        baud_tick = 1'b0;
        clk_tick  = 1'b0;
        model_reset();

        // 1: reset held for 3 cycles with requests pending.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_outputs", 32'({ack, err, busy, grant_id, gen_en}), 32'd0);
            chk("rst_gen_data", gen_baud_rate | gen_required_clk | gen_system_clk, 32'd0);
        end
        req = 2'b00;
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // 2: single valid request.
        rb[0] = 32'd9600; rc[0] = 32'd50_000;
        transact(2'b01, 2'b00, 1, 2, 1'b1);

        // 3: rejects (zero baud, rclk above half the system clock).
        rb[1] = 32'd0;    rc[1] = 32'd1000;
        transact(2'b10, 2'b00, 0, 0, 1'b1);
        rb[1] = 32'd9600; rc[1] = 32'd60_000;
        transact(2'b10, 2'b00, 0, 0, 1'b1);

        // 4: both requesters held -> alternating grants.
        rb[0] = 32'd4800;  rc[0] = 32'd20_000;
        rb[1] = 32'd19200; rc[1] = 32'd40_000;
        transact(2'b11, 2'b11, 2, 1, 1'b1);
        transact(2'b11, 2'b11, 0, 3, 1'b1);
        transact(2'b11, 2'b00, 1, 1, 1'b1);

        // 5: simultaneous ticks, then a lone baud tick waiting for clk_tick.
        transact(2'b01, 2'b00, 0, 0, 1'b1);
        transact(2'b10, 2'b00, 0, 4, 1'b1);

        // Randomised requests including boundary values.
        for (int t = 0; t < 14; t++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            for (int r = 0; r < NREQ; r++) begin
                rb[r] = pick_val();
                rc[r] = pick_val();
            end
            transact(m, 2'b00, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b1);
        end

`ifdef CFG_SCHED_TIMEOUT_EN
        // 6: no ticks -> timeout error with the generator disabled.
        rb[0] = 32'd9600; rc[0] = 32'd30_000;
        transact(2'b01, 2'b00, 0, 0, 1'b0);
`endif

        // Reset in the middle of the tick wait aborts silently.
        rb[0] = 32'd1200; rc[0] = 32'd10_000;
        req      = 2'b01;
        req_baud = {rb[1], rb[0]};
        req_rclk = {rc[1], rc[0]};
        for (int i = 0; i < 20 && !gen_en; i++) step();
        chk("pre_abort_gen_en", 32'(gen_en), 32'd1);
        step();
        step();
        rst = 1'b1;
        req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("abort_outputs", 32'({ack, err, busy, grant_id, gen_en}), 32'd0);
            chk("abort_gen_data", gen_baud_rate | gen_required_clk | gen_system_clk, 32'd0);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_resp", 32'({ack, err, busy}), 32'd0);
        end

        // Pointer restarts at 0 after reset.
        rb[1] = 32'd2400; rc[1] = 32'd25_000;
        transact(2'b11, 2'b00, 1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
